// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Optional feature macro used by counter_updown_mod: COUNTER_OVF_STICKY_EN.
package counter_pkg;

  // Encodings for the up_dn and sat_mode inputs.
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limit a parallel-load value to the highest legal count.
  function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                             input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler.sv
// count_prescaler: divides enabled clock cycles by PRESCALE and emits a
// single-cycle step on the last phase. The phase freezes while en is low and
// is cleared by clr (parallel load) or by reset. PRESCALE=1 reduces to step=en.
module count_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    // Every enabled cycle is a step; the phase register does not exist.
    logic unused_ok;
    assign unused_ok = clk ^ reset ^ clr;
    assign step      = en;
  end else begin : g_divide
    localparam int            PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign step = en && (pre == LAST);

    // Phase counter: cleared by reset or load, advances only while enabled.
    always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block evaluation order.
      if (reset || clr) begin
        pre <= '0;
      end else if (en) begin
        pre <= (pre == LAST) ? '0 : pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down modulo counter with prescaler,
// synchronous load, wrap-or-saturate boundary mode, terminal-count flag and
// a one-cycle wrap pulse.
// Optional: define COUNTER_OVF_STICKY_EN to add the ovf_sticky output, set on
// any wrap or any step blocked at the limit, cleared by reset or load.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter int               PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef COUNTER_OVF_STICKY_EN
  ,
  output logic             ovf_sticky
`endif
);

  logic             step;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .step  (step)
  );

  assign at_max       = (count == MAX_COUNT);
  assign at_zero      = (count == '0);
  assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

  // Terminal count tracks the limit in the current direction, regardless of en.
  assign tc = (up_dn == DIR_UP) ? at_max : at_zero;

  // Next count and wrap pulse; load outranks a step in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (!at_max) begin
          count_next = count + WIDTH'(1);
        end else if (sat_mode == MODE_WRAP) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_next = count - WIDTH'(1);
        end else if (sat_mode == MODE_WRAP) begin
          count_next = MAX_COUNT;
          wrap_next  = 1'b1;
        end
      end
    end
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  // Sticky overflow: any step taken while already at the limit (tc) either
  // wraps or is blocked by saturation; both latch the flag until reset/load.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      ovf_sticky <= 1'b0;
    end else if (step && tc) begin
      ovf_sticky <= 1'b1;
    end
  end
`endif

endmodule
